peripheral_bus: RTL and testbench

- Memory-mapped peripheral block sitting directly downstream of the single-cycle CPU's data-memory port.
- Decodes the upper address window 0x4000_0000–0x4000_001F.
- Contains a reloadable interval timer that raises the CPU's IRQ input, an LED register, a switch input, a 7-segment digit register and a free-running system tick counter.
- The CPU muxes this block's rdata with data-memory rdata on addr[30].

---
 rtl/peripheral_bus.sv | 142 ++++++++++++++
 tb/tb_peripheral_bus.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/peripheral_bus.sv
`default_nettype none
// ============================================================================
//  Module      : peripheral_bus
//  Description : Memory-mapped peripheral window for the single-cycle CPU.
//                Holds a reloadable interval timer with IRQ, LED register,
//                switch input, 7-segment digit register and a system tick
//                counter. Read data is combinational.
//  Revision    : 1.0  initial release
// ============================================================================
module peripheral_bus #(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter int          SW_WIDTH  = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                rd,
    input  logic                wr,
    input  logic [31:0]         addr,
    input  logic [31:0]         wdata,
    output logic [31:0]         rdata,
    output logic [7:0]          led,
    input  logic [SW_WIDTH-1:0] switch,
    output logic [11:0]         digi,
    output logic                irqout
);

    // Word offsets inside the 32-byte window
    localparam logic [2:0] C_OFF_TH      = 3'd0;
    localparam logic [2:0] C_OFF_TL      = 3'd1;
    localparam logic [2:0] C_OFF_TCON    = 3'd2;
    localparam logic [2:0] C_OFF_LED     = 3'd3;
    localparam logic [2:0] C_OFF_SWITCH  = 3'd4;
    localparam logic [2:0] C_OFF_DIGI    = 3'd5;
    localparam logic [2:0] C_OFF_SYSTICK = 3'd6;

    logic [31:0] r_th;
    logic [31:0] r_tl;
    logic [2:0]  r_tcon;
    logic [7:0]  r_led;
    logic [11:0] r_digi;
    logic [31:0] r_systick;

    logic        w_in_window;
    logic [2:0]  w_off;
    logic        w_wr_th;
    logic        w_wr_tl;
    logic        w_wr_tcon;
    logic        w_wr_led;
    logic        w_wr_digi;
    logic        w_overflow;
    logic [31:0] w_switch_ext;

    assign w_in_window  = (addr[31:5] == BASE_ADDR[31:5]);
    assign w_off        = addr[4:2];
    assign w_wr_th      = wr && w_in_window && (w_off == C_OFF_TH);
    assign w_wr_tl      = wr && w_in_window && (w_off == C_OFF_TL);
    assign w_wr_tcon    = wr && w_in_window && (w_off == C_OFF_TCON);
    assign w_wr_led     = wr && w_in_window && (w_off == C_OFF_LED);
    assign w_wr_digi    = wr && w_in_window && (w_off == C_OFF_DIGI);
    // Overflow is a timer event; it is evaluated even if software rewrites TL
    assign w_overflow   = r_tcon[0] && (r_tl == 32'hFFFF_FFFF);
    assign w_switch_ext = 32'(switch);

    // Reload value: software-written only, used at the next overflow
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_th <= 32'd0;
        end else if (w_wr_th) begin
            r_th <= wdata;
        end
    end

    // Counter: software write wins over increment/reload
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tl <= 32'd0;
        end else if (w_wr_tl) begin
            r_tl <= wdata;
        end else if (r_tcon[0]) begin
            r_tl <= w_overflow ? r_th : (r_tl + 32'd1);
        end
    end

    // Control/status: a pending overflow interrupt survives a concurrent write
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tcon <= 3'd0;
        end else if (w_wr_tcon) begin
            r_tcon[1:0] <= wdata[1:0];
            r_tcon[2]   <= wdata[2] | (w_overflow & r_tcon[1]);
        end else if (w_overflow && r_tcon[1]) begin
            r_tcon[2] <= 1'b1;
        end
    end

    // LED and 7-segment output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_led  <= 8'd0;
            r_digi <= 12'd0;
        end else begin
            if (w_wr_led) begin
                r_led <= wdata[7:0];
            end
            if (w_wr_digi) begin
                r_digi <= wdata[11:0];
            end
        end
    end

    // Free-running tick counter, wraps naturally
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_systick <= 32'd0;
        end else begin
            r_systick <= r_systick + 32'd1;
        end
    end

    // Combinational read mux; zero outside the window or when not reading
    always_comb begin
        rdata = 32'd0;
        if (rd && w_in_window) begin
            case (w_off)
                C_OFF_TH:      rdata = r_th;
                C_OFF_TL:      rdata = r_tl;
                C_OFF_TCON:    rdata = {29'd0, r_tcon};
                C_OFF_LED:     rdata = {24'd0, r_led};
                C_OFF_SWITCH:  rdata = w_switch_ext;
                C_OFF_DIGI:    rdata = {20'd0, r_digi};
                C_OFF_SYSTICK: rdata = r_systick;
                default:       rdata = 32'd0;
            endcase
        end
    end

    assign led    = r_led;
    assign digi   = r_digi;
    assign irqout = r_tcon[2];

endmodule
`default_nettype wire

// File: tb/tb_peripheral_bus.sv
`default_nettype none
// ============================================================================
//  Module      : tb_peripheral_bus
//  Description : Directed self-checking bench for peripheral_bus.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_peripheral_bus;

    localparam logic [31:0] C_BASE = 32'h4000_0000;

    logic        clk;
    logic        reset;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [7:0]  led;
    logic [7:0]  switch;
    logic [11:0] digi;
    logic        irqout;

    int errors = 0;
    int checks = 0;

    peripheral_bus #(
        .BASE_ADDR (C_BASE),
        .SW_WIDTH  (8)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .rd     (rd),
        .wr     (wr),
        .addr   (addr),
        .wdata  (wdata),
        .rdata  (rdata),
        .led    (led),
        .switch (switch),
        .digi   (digi),
        .irqout (irqout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Write takes effect on the next posedge; returns 1 time unit after it
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        wr    = 1'b1;
        addr  = a;
        wdata = d;
        @(posedge clk);
        #1;
        wr = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        rd   = 1'b1;
        addr = a;
        #1;
        d  = rdata;
        rd = 1'b0;
    endtask

    logic [31:0] v;
    logic [31:0] t0;

    initial begin
        reset  = 1'b1;
        rd     = 1'b0;
        wr     = 1'b0;
        addr   = 32'd0;
        wdata  = 32'd0;
        switch = 8'h3C;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        check("irq_reset", {31'd0, irqout}, 32'd0);
        check("led_reset", {24'd0, led}, 32'd0);
        check("digi_reset", {20'd0, digi}, 32'd0);
        bus_read(C_BASE + 32'h00, v); check("th_reset", v, 32'd0);
        bus_read(C_BASE + 32'h04, v); check("tl_reset", v, 32'd0);
        bus_read(C_BASE + 32'h08, v); check("tcon_reset", v, 32'd0);
        bus_read(C_BASE + 32'h1C, v); check("unmapped", v, 32'd0);

        // LED / digit / switch
        bus_write(C_BASE + 32'h0C, 32'h0000_01A5);
        check("led_out", {24'd0, led}, 32'h0000_00A5);
        bus_write(C_BASE + 32'h14, 32'h0000_0F7E);
        check("digi_out", {20'd0, digi}, 32'h0000_0F7E);
        bus_read(C_BASE + 32'h14, v); check("digi_read", v, 32'h0000_0F7E);
        bus_read(C_BASE + 32'h10, v); check("switch_read", v, 32'h0000_003C);

        // Decode: outside the window nothing changes
        bus_write(C_BASE + 32'h20, 32'h0000_0055);
        bus_read(C_BASE + 32'h00, v); check("alias_th", v, 32'd0);
        bus_write(32'h0000_000C, 32'h0000_0033);
        check("lowaddr_led", {24'd0, led}, 32'h0000_00A5);
        bus_write(C_BASE + 32'h18, 32'h0000_0000);
        addr = C_BASE + 32'h0C;
        rd   = 1'b0;
        #1;
        check("rd_low", rdata, 32'd0);

        // systick difference across 3 cycles
        @(posedge clk); #1;
        bus_read(C_BASE + 32'h18, t0);
        repeat (3) @(posedge clk);
        #1;
        bus_read(C_BASE + 32'h18, v);
        check("systick_delta", v - t0, 32'd3);

        // Interval period: overflow 4 edges after enable
        bus_write(C_BASE + 32'h00, 32'hFFFF_FFFC);
        bus_write(C_BASE + 32'h04, 32'hFFFF_FFFC);
        bus_write(C_BASE + 32'h08, 32'h0000_0003);
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk); #1;
            check($sformatf("irq_wait%0d", i), {31'd0, irqout}, 32'd0);
        end
        @(posedge clk); #1;
        check("irq_rise", {31'd0, irqout}, 32'd1);
        bus_read(C_BASE + 32'h04, v); check("tl_reload", v, 32'hFFFF_FFFC);
        bus_read(C_BASE + 32'h08, v); check("tcon_pending", v, 32'h0000_0007);

        // Acknowledge: clears, then next overflow reasserts
        bus_write(C_BASE + 32'h08, 32'h0000_0003);
        check("irq_ack", {31'd0, irqout}, 32'd0);
        bus_read(C_BASE + 32'h04, v); check("tl_after_ack", v, 32'hFFFF_FFFD);
        for (int i = 1; i <= 2; i++) begin
            @(posedge clk); #1;
            check($sformatf("irq_rewait%0d", i), {31'd0, irqout}, 32'd0);
        end
        @(posedge clk); #1;
        check("irq_reassert", {31'd0, irqout}, 32'd1);

        // TH write does not disturb the running count
        bus_write(C_BASE + 32'h00, 32'hFFFF_FFF0);
        bus_read(C_BASE + 32'h04, v); check("tl_th_write", v, 32'hFFFF_FFFD);
        check("irq_held", {31'd0, irqout}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        bus_read(C_BASE + 32'h04, v); check("tl_new_reload", v, 32'hFFFF_FFF0);

        // TCON write coinciding with overflow keeps the interrupt
        bus_write(C_BASE + 32'h04, 32'hFFFF_FFFF);
        bus_write(C_BASE + 32'h08, 32'h0000_0003);
        bus_read(C_BASE + 32'h08, v); check("tcon_collide", v, 32'h0000_0007);
        check("irq_collide", {31'd0, irqout}, 32'd1);
        bus_read(C_BASE + 32'h04, v); check("tl_collide", v, 32'hFFFF_FFF0);

        // Disable: TL holds
        bus_write(C_BASE + 32'h08, 32'h0000_0000);
        bus_read(C_BASE + 32'h04, v); check("tl_disable", v, 32'hFFFF_FFF1);
        repeat (2) @(posedge clk);
        #1;
        bus_read(C_BASE + 32'h04, v); check("tl_hold", v, 32'hFFFF_FFF1);

        // TH all-ones: overflow every cycle, TL stays at TH
        bus_write(C_BASE + 32'h00, 32'hFFFF_FFFF);
        bus_write(C_BASE + 32'h04, 32'hFFFF_FFFF);
        bus_write(C_BASE + 32'h08, 32'h0000_0001);
        repeat (2) @(posedge clk);
        #1;
        bus_read(C_BASE + 32'h04, v); check("tl_all_ones", v, 32'hFFFF_FFFF);
        bus_read(C_BASE + 32'h08, v); check("tcon_noirqen", v, 32'h0000_0001);

        // Asynchronous reset mid-count with interrupt pending
        bus_write(C_BASE + 32'h00, 32'h0000_0000);
        bus_write(C_BASE + 32'h04, 32'h0000_0005);
        bus_write(C_BASE + 32'h08, 32'h0000_0007);
        check("irq_preset", {31'd0, irqout}, 32'd1);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("irq_async", {31'd0, irqout}, 32'd0);
        check("led_async", {24'd0, led}, 32'd0);
        bus_read(C_BASE + 32'h04, v); check("tl_async", v, 32'd0);
        bus_read(C_BASE + 32'h08, v); check("tcon_async", v, 32'd0);
        bus_read(C_BASE + 32'h14, v); check("digi_async", v, 32'd0);
        bus_read(C_BASE + 32'h10, v); check("switch_in_reset", v, 32'h0000_003C);
        @(posedge clk);
        #1;
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
